// File: rtl/polarfir_div_pkg.sv
// polarfir_div_pkg
// Shared constants and types for the sequential 36s/12u divider:
//   datapath widths, saturation bounds and the controller state encoding.
package polarfir_div_pkg;

  localparam int W_DIVIDEND = 36;
  localparam int W_DIVISOR  = 12;
  localparam int W_QUOT     = 24;
  localparam int W_REM      = 13;
  localparam int W_CNT      = 6;

  // Index of the final radix-2 step (steps are counted 0..W_DIVIDEND-1).
  localparam logic [W_CNT-1:0] LAST_STEP = W_CNT'(W_DIVIDEND - 1);

  localparam logic [W_QUOT-1:0] QMAX = 24'h7F_FFFF;
  localparam logic [W_QUOT-1:0] QMIN = 24'h80_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/polarfir_div_step.sv
// polarfir_div_step
// One restoring radix-2 division step (purely combinational).
// Ports:
//   i_part  partial remainder entering the step (always < i_den when i_den != 0)
//   i_bit   next dividend bit, MSB first
//   i_den   divisor
//   o_q     quotient bit produced by this step
//   o_part  partial remainder leaving the step
module polarfir_div_step
  import polarfir_div_pkg::*;
(
  input  logic [W_DIVISOR-1:0] i_part,
  input  logic                 i_bit,
  input  logic [W_DIVISOR-1:0] i_den,
  output logic                 o_q,
  output logic [W_DIVISOR-1:0] o_part
);

  logic [W_DIVISOR+1:0] w_diff;

  assign w_diff = {1'b0, i_part, i_bit} - {2'b00, i_den};

  // Because i_part < i_den, a non-negative difference is always below i_den,
  // so both top bits are zero exactly when the trial subtraction succeeds.
  assign o_q    = (w_diff[W_DIVISOR+1:W_DIVISOR] == 2'b00);
  assign o_part = o_q ? w_diff[W_DIVISOR-1:0] : {i_part[W_DIVISOR-2:0], i_bit};

endmodule

// File: rtl/polarfir_div_36s_12ns_24_seq.sv
// polarfir_div_36s_12ns_24_seq
// Sequential signed/unsigned divider: 36-bit signed dividend by 12-bit
// unsigned divisor, 24-bit signed quotient (truncated toward zero) and
// 13-bit signed remainder (sign of the dividend). Fixed 36-step latency.
// Optional build macro: POLARFIR_DIV_SAT_EN -- clamp overflowing quotients
// to QMAX/QMIN and raise sat; otherwise the low 24 bits are returned.
// Ports:
//   clk, reset (async, active low), ce (global clock enable)
//   in_valid/in_ready, din0 (dividend), din1 (divisor)
//   out_valid/out_ready, dout (quotient), rem, div_by_zero, sat
//
// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready=1
// S_CALC | running the 36 radix-2 steps
// S_DONE | result held until out_ready
module polarfir_div_36s_12ns_24_seq
  import polarfir_div_pkg::*;
#(
  parameter int ID = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_DIVIDEND-1:0] din0,
  input  logic [W_DIVISOR-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W_QUOT-1:0]     dout,
  output logic [W_REM-1:0]      rem,
  output logic                  div_by_zero,
  output logic                  sat
);

  // ID is an instance tag only.
  if (ID < 0) begin : g_id_tag
  end

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_in_ready;
  logic [W_DIVIDEND-1:0] r_mag;
  logic [W_DIVISOR-1:0]  r_part;
  logic [W_DIVISOR-1:0]  r_den;
  logic                  r_neg;
  logic [W_CNT-1:0]      r_cnt;
  logic [W_QUOT-1:0]     r_dout;
  logic [W_REM-1:0]      r_rem;
  logic                  r_dz;
  logic                  r_sat;

  logic                  w_accept;
  logic                  w_q;
  logic [W_DIVISOR-1:0]  w_part_next;
  logic [W_QUOT-1:0]     w_qlow;
  logic [W_QUOT-1:0]     w_dout_fin;
  logic [W_REM-1:0]      w_rem_fin;
  logic                  w_dz_fin;
  logic                  w_sat_fin;

  polarfir_div_step u_step (
    .i_part (r_part),
    .i_bit  (r_mag[W_DIVIDEND-1]),
    .i_den  (r_den),
    .o_q    (w_q),
    .o_part (w_part_next)
  );

  // r_in_ready is only ever 1 in S_IDLE, so it also qualifies the state.
  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_STEP) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else if (ce) begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == S_IDLE);
    end
  end

  // Final result, formed from the values the last step is about to produce.
  assign w_qlow = {r_mag[W_QUOT-2:0], w_q};

`ifdef POLARFIR_DIV_SAT_EN
  logic [W_DIVIDEND-1:0] w_qmag;
  logic                  w_ovf;
  assign w_qmag = {r_mag[W_DIVIDEND-2:0], w_q};
  // A negative quotient may reach -2^23; a positive one only 2^23-1.
  assign w_ovf  = r_neg ? (w_qmag > W_DIVIDEND'(2**23))
                        : (w_qmag > W_DIVIDEND'(2**23 - 1));
`endif

  always_comb begin
    w_dout_fin = r_neg ? -w_qlow : w_qlow;
    w_rem_fin  = r_neg ? -{1'b0, w_part_next} : {1'b0, w_part_next};
    w_dz_fin   = 1'b0;
    w_sat_fin  = 1'b0;
`ifdef POLARFIR_DIV_SAT_EN
    if (w_ovf) begin
      w_dout_fin = r_neg ? QMIN : QMAX;
      w_sat_fin  = 1'b1;
    end
`endif
    if (r_den == '0) begin
      w_dout_fin = r_neg ? QMIN : QMAX;
      w_rem_fin  = '0;
      w_dz_fin   = 1'b1;
      w_sat_fin  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mag  <= '0;
      r_part <= '0;
      r_den  <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // -2^35 negates to itself, which is the correct unsigned magnitude.
            r_mag  <= din0[W_DIVIDEND-1] ? -din0 : din0;
            r_neg  <= din0[W_DIVIDEND-1];
            r_den  <= din1;
            r_part <= '0;
            r_cnt  <= '0;
          end
        end
        S_CALC: begin
          r_mag  <= {r_mag[W_DIVIDEND-2:0], w_q};
          r_part <= w_part_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_dout <= w_dout_fin;
            r_rem  <= w_rem_fin;
            r_dz   <= w_dz_fin;
            r_sat  <= w_sat_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign dout        = r_dout;
  assign rem         = r_rem;
  assign div_by_zero = r_dz;
  assign sat         = r_sat;

endmodule

// File: tb/tb_polarfir_div_36s_12ns_24_seq.sv
// Directed self-checking bench for polarfir_div_36s_12ns_24_seq.
module tb_polarfir_div_36s_12ns_24_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] dout;
  logic [12:0] rem;
  logic        div_by_zero;
  logic        sat;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  polarfir_div_36s_12ns_24_seq #(.ID(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .sat         (sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair at a negedge and hold it through the accepting edge.
  task automatic start_op(input logic [35:0] a, input logic [11:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count enabled edges after acceptance until out_valid rises (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [35:0] a, input logic [11:0] b,
                       input logic [23:0] eq, input logic [12:0] er,
                       input logic edz, input logic esat);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check({tag, " latency"}, lat, 36);
    check({tag, " dout"}, dout, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " div_by_zero"}, div_by_zero, edz);
    check({tag, " sat"}, sat, esat);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    check({tag, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset dout", dout, 0);
    check("reset rem", rem, 0);
    check("reset flags", {div_by_zero, sat}, 0);

    reset = 1'b1;
    #1;
    check("in_ready before first edge", in_ready, 0);
    @(posedge clk); @(negedge clk);
    check("in_ready after first edge", in_ready, 1);

    do_op("1000/7",    36'd1000,        12'd7,    24'h00008E, 13'h0006, 1'b0, 1'b0);
    do_op("-1000/7",   36'hFFFFFFC18,   12'd7,    24'hFFFF72, 13'h1FFA, 1'b0, 1'b0);
    do_op("123456789/1000", 36'h0075BCD15, 12'd1000, 24'h01E240, 13'h0315, 1'b0, 1'b0);
`ifdef POLARFIR_DIV_SAT_EN
    do_op("max/1",     36'h7FFFFFFFF,   12'd1,    24'h7FFFFF, 13'h0000, 1'b0, 1'b1);
    do_op("-2^35/4095", 36'h800000000,  12'd4095, 24'h800000, 13'h1800, 1'b0, 1'b1);
`else
    do_op("max/1",     36'h7FFFFFFFF,   12'd1,    24'hFFFFFF, 13'h0000, 1'b0, 1'b0);
    do_op("-2^35/4095", 36'h800000000,  12'd4095, 24'h7FF800, 13'h1800, 1'b0, 1'b0);
`endif
    do_op("-2^23/1",   36'hFFF800000,   12'd1,    24'h800000, 13'h0000, 1'b0, 1'b0);
    do_op("5/0",       36'd5,           12'd0,    24'h7FFFFF, 13'h0000, 1'b1, 1'b0);
    do_op("-5/0",      36'hFFFFFFFFB,   12'd0,    24'h800000, 13'h0000, 1'b1, 1'b0);

    // Backpressure: result held while out_ready=0, ce toggling, in_valid pulsed.
    start_op(36'd1000, 12'd7);
    wait_result(lat);
    check("hold latency", lat, 36);
    for (int i = 0; i < 10; i++) begin
      ce = i[0];
      in_valid = 1'b1;
      din0 = 36'(i + 50);
      din1 = 12'd3;
      @(posedge clk); @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold dout/rem", {dout, rem}, {24'h00008E, 13'h0006});
      check("hold in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("hold release out_valid", out_valid, 0);
    check("hold release in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no stray accept", {in_ready, out_valid}, 2'b10);

    // Reset in the middle of CALC.
    start_op(36'd999, 12'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid-calc reset out_valid", out_valid, 0);
    check("mid-calc reset in_ready", in_ready, 0);
    check("mid-calc reset dout", dout, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no result after reset", seen, 0);
    do_op("1000/7 after reset", 36'd1000, 12'd7, 24'h00008E, 13'h0006, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/polarfir_div_36s_12ns_24_seq.md
POLARFIR_DIV_36S_12NS_24_SEQ -- requirements
Module: polarfir_div_36s_12ns_24_seq

Interface
REQ-001 SHALL have parameter: ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have port: clk  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ce  in  1  clock enable; when low, all registers hold.
REQ-005 SHALL have port: in_valid  in  1  operand pair valid.
REQ-006 SHALL have port: in_ready  out  1  divider idle, can accept operands.
REQ-007 SHALL have port: din0  in  36  signed dividend.
REQ-008 SHALL have port: din1  in  12  unsigned divisor.
REQ-009 SHALL have port: out_valid  out  1  result valid.
REQ-010 SHALL have port: out_ready  in  1  downstream accepts result.
REQ-011 SHALL have port: dout  out  24  signed quotient.
REQ-012 SHALL have port: rem  out  13  signed remainder.
REQ-013 SHALL have port: div_by_zero  out  1  flag, qualified by out_valid.
REQ-014 SHALL have port: sat  out  1  quotient overflow flag, qualified by out_valid.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CALC and DONE; every transition requires ce=1.
REQ-016 SHALL accept operands at an edge where in_valid, in_ready and ce are all 1, latching |din0|, din0 sign and din1, clearing a 6-bit counter, and entering CALC.
REQ-017 SHALL, in CALC, perform one restoring radix-2 step per enabled edge on the 36-bit magnitude, MSB first, for exactly 36 steps.
REQ-018 SHALL register the final quotient, remainder and flags on the 36th CALC edge and enter DONE at that edge; out_valid then equals 1.
REQ-019 SHALL have a latency of 36 enabled edges from acceptance to out_valid=1, independent of operand values; there is no early termination.
REQ-020 SHALL hold dout, rem and the flags stable while out_valid=1 and out_ready=0.
REQ-021 SHALL return from DONE to IDLE at an edge where out_valid, out_ready and ce are all 1.
REQ-022 SHALL drive in_ready from a register: 1 in IDLE, and 0 in CALC, in DONE and during reset.
REQ-023 SHALL ignore in_valid whenever in_ready=0.
REQ-024 SHALL round the quotient toward zero; the remainder has the sign of the dividend and |rem| < din1.
REQ-025 SHALL, when din1=0, produce: div_by_zero=1; dout=0x7FFFFF if din0>=0, else 0x800000; rem=0; full latency still applies.
REQ-026 SHALL treat din0=-2^35 correctly; its magnitude fits in the 36-bit unsigned datapath.
REQ-027 SHALL, when a nonzero-divisor quotient falls outside [-2^23, 2^23-1], behave per REQ-031/REQ-032.

Reset
REQ-028 SHALL, on reset=0, asynchronously force: state=IDLE, in_ready=0, out_valid=0, dout=0, rem=0, div_by_zero=0, sat=0, counter=0.
REQ-029 SHALL raise in_ready at the first enabled edge after reset deasserts.
REQ-030 SHALL discard any operation in flight when reset asserts mid-CALC or mid-DONE; no result is emitted.

Configuration
REQ-031 SHALL, with POLARFIR_DIV_SAT_EN defined, clamp an overflowing quotient to 0x7FFFFF (positive) or 0x800000 (negative) and set sat=1.
REQ-032 SHALL, without POLARFIR_DIV_SAT_EN, output the low 24 bits of the two's-complement true quotient, with sat tied to 0.

Structure
REQ-033 SHALL take the following from package polarfir_div_pkg: width constants (36, 12, 24, 13), QMAX/QMIN, and the FSM state enum.
REQ-034 SHALL instantiate the combinational sub-module polarfir_div_step (trial subtract, quotient bit, next partial remainder) once.

Verification
REQ-035 SHALL cover: din0=1000, din1=7 -> after 36 edges dout=142, rem=6, flags 0.
REQ-036 SHALL cover: din0=-1000, din1=7 -> dout=0xFFFF72 (-142), rem=-6.
REQ-037 SHALL cover: din0=0x7FFFFFFFF, din1=1 -> with the macro, dout=0x7FFFFF and sat=1; without it, dout=0xFFFFFF and sat=0.
REQ-038 SHALL cover: din0=5, din1=0 -> dout=0x7FFFFF, div_by_zero=1; and din0=-5, din1=0 -> dout=0x800000.
REQ-039 SHALL cover: out_ready held 0 for 10 cycles, with a new in_valid pulsed and ce toggled -> outputs stable, nothing accepted; out_ready=1 -> IDLE, in_ready=1 on the next edge.
REQ-040 SHALL cover: reset asserted at CALC step 20 -> out_valid=0 immediately, no result emitted, and a subsequent operation 1000/7 returns 142.
